peridot_scif_rx_arbiter: RTL

//  Shares the single SCIF RXD byte serializer (host-bound direction) among NUM_CH byte sources in the

---
 rtl/peridot_scif_rx_arbiter.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/peridot_scif_rx_arbiter.sv
// peridot_scif_rx_arbiter
// Round-robin arbiter sharing the SCIF RXD byte serializer among NUM_CH
// byte sources. Inserts a channel-select header (7C, 80|ch) whenever the
// granted channel differs from the last announced one, and escapes data
// bytes equal to 7C/7D as 7D, byte^20 so the host can demultiplex.
//
// Optional feature: define PERIDOT_SCIF_ARB_RESYNC_EN to forget the announced
// channel after RESYNC_IDLE fully idle cycles, so the next grant re-emits the
// header even for the same channel.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | arbitrating; picks next valid channel after grant_ch
// S_HDR_ESC| loading header escape 7C
// S_HDR_CH | loading channel byte 80|grant_ch, latching it as announced
// S_DATA   | forwarding bytes of grant_ch, up to MAX_BURST
// S_DATA_ESC| loading the second half (byte^20) of an escaped data byte
`timescale 1ns/1ps
module peridot_scif_rx_arbiter #(
    parameter int NUM_CH      = 4,
    parameter int MAX_BURST   = 16,
    parameter int RESYNC_IDLE = 1024
) (
    input  logic                scif_clock_sig,
    input  logic                reset_sig,
    input  logic [NUM_CH-1:0]   req_valid,
    input  logic [8*NUM_CH-1:0] req_data,
    output logic [NUM_CH-1:0]   req_ready,
    output logic                ser_valid,
    output logic [7:0]          ser_data,
    input  logic                ser_ready,
    output logic [2:0]          grant_ch,
    output logic                busy
);

    localparam logic [7:0] ESC_CH    = 8'h7C;
    localparam logic [7:0] ESC_DAT   = 8'h7D;
    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_ESC,
        S_HDR_CH,
        S_DATA,
        S_DATA_ESC
    } state_t;

    state_t     state;
    logic [2:0] cur_ch;
    logic       cur_ch_valid;
    logic       cur_valid_eff;
    logic [7:0] burst_cnt;
    logic [7:0] burst_nxt;
    logic [7:0] esc_byte;
    logic       slot_free;
    logic       gnt_valid;
    logic [7:0] gnt_byte;
    logic       pick_found;
    logic [2:0] pick_ch;

    assign slot_free = !ser_valid || ser_ready;
    assign burst_nxt = burst_cnt + 8'd1;
    assign busy      = (state != S_IDLE) || ser_valid;

    // Round-robin pick starting one past the last granted channel.
    always_comb begin
        pick_found = 1'b0;
        pick_ch    = grant_ch;
        for (int k = 1; k <= NUM_CH; k++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!pick_found && req_valid[i] && ((int'(grant_ch) + k) % NUM_CH == i)) begin
                    pick_found = 1'b1;
                    pick_ch    = 3'(i);
                end
            end
        end
    end

    // Granted channel's request, and the ready strobe back to it only.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_byte  = 8'h00;
        req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_ch == 3'(i)) begin
                gnt_valid = req_valid[i];
                gnt_byte  = req_data[8*i +: 8];
                if (state == S_DATA) req_ready[i] = slot_free;
            end
        end
    end

`ifdef PERIDOT_SCIF_ARB_RESYNC_EN
    localparam logic [15:0] IDLE_LIM = 16'(RESYNC_IDLE);
    logic [15:0] idle_cnt;
    logic        idle_cnt_en;
    logic        idle_hit;

    assign idle_cnt_en   = (state == S_IDLE) && !ser_valid;
    assign idle_hit      = idle_cnt_en && (idle_cnt + 16'd1 == IDLE_LIM);
    assign cur_valid_eff = cur_ch_valid && !idle_hit;

    // Saturating count of fully idle cycles; any activity restarts it.
    always_ff @(posedge scif_clock_sig or posedge reset_sig) begin
        if (reset_sig)            idle_cnt <= 16'd0;
        else if (!idle_cnt_en)    idle_cnt <= 16'd0;
        else if (idle_cnt != IDLE_LIM) idle_cnt <= idle_cnt + 16'd1;
    end
`else
    assign cur_valid_eff = cur_ch_valid;
`endif

    // Arbitration FSM and the registered output byte slot.
    always_ff @(posedge scif_clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state        <= S_IDLE;
            ser_valid    <= 1'b0;
            ser_data     <= 8'hFF;
            grant_ch     <= 3'(NUM_CH - 1);
            cur_ch       <= 3'd0;
            cur_ch_valid <= 1'b0;
            burst_cnt    <= 8'd0;
            esc_byte     <= 8'h00;
        end else begin
            if (slot_free) ser_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_ch  <= pick_ch;
                        burst_cnt <= 8'd0;
                        state     <= (!cur_valid_eff || pick_ch != cur_ch) ? S_HDR_ESC : S_DATA;
                    end
                end
                S_HDR_ESC: begin
                    if (slot_free) begin
                        ser_valid <= 1'b1;
                        ser_data  <= ESC_CH;
                        state     <= S_HDR_CH;
                    end
                end
                S_HDR_CH: begin
                    if (slot_free) begin
                        ser_valid    <= 1'b1;
                        ser_data     <= 8'h80 | {5'b0, grant_ch};
                        cur_ch       <= grant_ch;
                        cur_ch_valid <= 1'b1;
                        state        <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!gnt_valid) begin
                        state <= S_IDLE;
                    end else if (slot_free) begin
                        ser_valid <= 1'b1;
                        burst_cnt <= burst_nxt;
                        if (gnt_byte == ESC_CH || gnt_byte == ESC_DAT) begin
                            ser_data <= ESC_DAT;
                            esc_byte <= gnt_byte ^ 8'h20;
                            state    <= S_DATA_ESC;
                        end else begin
                            ser_data <= gnt_byte;
                            if (burst_nxt == BURST_LIM) state <= S_IDLE;
                        end
                    end
                end
                S_DATA_ESC: begin
                    if (slot_free) begin
                        ser_valid <= 1'b1;
                        ser_data  <= esc_byte;
                        state     <= (burst_cnt == BURST_LIM) ? S_IDLE : S_DATA;
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef PERIDOT_SCIF_ARB_RESYNC_EN
            if (idle_hit) cur_ch_valid <= 1'b0;
`endif
        end
    end

endmodule
